seg7_display_decoder: RTL
=========================

Name: seg7_display_decoder

Overview:
- Receiving end of the switch-to-display path: monitors an 8-bit active-low seven-segment drive pattern and recovers the displayed digit (0-9), decimal point, blank and invalid status.
- Filters glitches with a stability counter and suppresses duplicates.
- Hands each newly committed reading to a consumer over a valid/ready handshake.
- Used as the display-side checker and loop-back decoder for the encoder/display logic.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is committed. Legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- seg_in  input  8  active-low segment pattern; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp
- out_ready  input  1  consumer accepts the current reading
- out_valid  output  1  committed reading pending
- digit  output  4  decoded digit 0-9; 4'hF when blank or invalid
- dp  output  1  decimal point lit (seg_in[0]==0)
- blank  output  1  segments a-g all off
- err  output  1  a-g pattern is neither a digit nor blank
- overrun  output  1  sticky; a pending reading was overwritten before acceptance

Behaviour:
- Reset (rst low, asynchronous, any state): digit=4'hF, dp=0, blank=1, err=0, out_valid=0, overrun=0.
- Reset internal state: candidate cand=8'hFF, counter cnt=0, last committed code last=8'hFF.
- Decode uses seg_in[7:1] only; dp is taken from bit0. Valid a-g codes (bits 7:1):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
  - anything else sets err=1, digit=F, blank=0
- Stability filter, evaluated at every rising edge:
  - seg_in != cand: cand<=seg_in, cnt<=1.
  - seg_in == cand and cnt < STABLE_CYCLES: cnt<=cnt+1.
  - cnt saturates at STABLE_CYCLES; no further increments.
- Commit: at the edge where cnt goes STABLE_CYCLES-1 -> STABLE_CYCLES, if cand != last:
  - digit, dp, blank and err are loaded from the decode of cand; last<=cand; out_valid<=1.
  - If cand == last, nothing is committed.
- Latency: a new pattern first sampled at edge E1 is committed at edge E(STABLE_CYCLES). Outputs are visible after that edge, i.e. STABLE_CYCLES edges after first sample.
- The full 8-bit code is compared, so a dp change alone is a new reading.
- Handshake: out_valid stays high until an edge with out_valid=1 and out_ready=1, which clears it. Output data is stable while out_valid=1 unless overwritten.
- Simultaneous commit and accept at the same edge: new data loads, out_valid stays 1, overrun unchanged.
- Commit while out_valid=1 and out_ready=0: data overwritten, out_valid stays 1, overrun<=1.
- overrun clears only on reset.
- out_ready while out_valid=0: ignored.
- Reset asserted mid-count: the partial count is discarded. After release, a pattern needs the full STABLE_CYCLES samples.
- A blank input held through reset release produces no reading, because last=8'hFF at reset.

Test Plan:
- Reset then start: rst=0 with seg_in=8'b00000011 -> all outputs at reset values. Release and hold the pattern -> out_valid rises exactly after the 4th edge, digit=0, dp=0, blank=0, err=0.
- Glitch rejection: seg_in=8'b10011111 for 3 cycles, then 8'b00100101 held -> no reading for 1. One reading digit=2 committed 4 edges after the switch.
- Dedup and handshake: hold digit 2 for 20 cycles, pulse out_ready once -> exactly one reading and out_valid clears. Change seg_in to 8'b00100100 (2 with dp) -> new reading digit=2, dp=1.
- Invalid and blank: seg_in=8'b11110000 -> err=1, digit=F, blank=0. Then 8'b11111111 -> blank=1, err=0, digit=F.
- Overrun and simultaneous accept:
  - Commit 5 (8'b01001001) with out_ready=0, then commit 6 (8'b01000001) -> digit=6, overrun=1.
  - Commit 7 (8'b00011111) on the same edge as out_ready=1 -> digit=7, out_valid=1, overrun stays 1.
- Async reset mid-count: hold 8'b10011001 for 2 edges, pulse rst low between edges -> outputs reset immediately without waiting for a clock. After release, digit=4 commits 4 edges after re-sampling.

Source files
------------

// File: rtl/seg7_display_decoder.sv
// seg7_display_decoder
// Watches an active-low seven-segment drive pattern and recovers the digit,
// decimal point, blank and invalid status. A new pattern has to hold steady
// for STABLE_CYCLES samples before it counts. A repeat of the last committed
// pattern is dropped. Each new reading goes to a consumer over valid/ready.
module seg7_display_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] digit,
  output logic       dp,
  output logic       blank,
  output logic       err,
  output logic       overrun
);

  localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_COMMIT = 8'(STABLE_CYCLES - 1);

  logic [7:0] cand;
  logic [7:0] cnt;
  logic [7:0] last;

  logic [3:0] dec_digit;
  logic       dec_blank;
  logic       dec_err;
  logic       same;
  logic       commit;

  // Decode the a-g part of the candidate; anything unrecognised is flagged as an error
  always_comb begin
    dec_digit = 4'hF;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (cand[7:1])
      7'b0000001: dec_digit = 4'd0;
      7'b1001111: dec_digit = 4'd1;
      7'b0010010: dec_digit = 4'd2;
      7'b0000110: dec_digit = 4'd3;
      7'b1001100: dec_digit = 4'd4;
      7'b0100100: dec_digit = 4'd5;
      7'b0100000: dec_digit = 4'd6;
      7'b0001111: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0000100: dec_digit = 4'd9;
      7'b1111111: dec_blank = 1'b1;
      default:    dec_err   = 1'b1;
    endcase
  end

  // A commit fires on the sample that takes the count to its final value, and only for a fresh code
  always_comb begin
    same   = (seg_in == cand);
    commit = same && (cnt == CNT_COMMIT) && (cand != last);
  end

  // Stability filter: restart on any change, count identical samples up to saturation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand <= 8'hFF;
      cnt  <= 8'd0;
    end else if (!same) begin
      cand <= seg_in;
      cnt  <= 8'd1;
    end else if (cnt < CNT_MAX) begin
      cnt  <= cnt + 8'd1;
    end
  end

  // Remember the most recently committed code so that repeats are suppressed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 8'hFF;
    end else if (commit) begin
      last <= cand;
    end
  end

  // Output register and handshake; a commit onto an unaccepted reading sets the sticky overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit     <= 4'hF;
      dp        <= 1'b0;
      blank     <= 1'b1;
      err       <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (commit) begin
      digit     <= dec_digit;
      dp        <= ~cand[0];
      blank     <= dec_blank;
      err       <= dec_err;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
